// File: rtl/mtimer.sv
// mtimer: free-running 64-bit mtime (enable + prescaler) with NUM_CMP compare channels driving registered level IRQs.
// Latency: read data and ready_out one cycle after sel_in, write commits on the ready cycle; IRQ follows a register change by one cycle.
// Backpressure: none; master holds sel_in until ready_out. `define MTIMER_SNAPSHOT_EN adds a tear-free MTIMEH shadow.
module mtimer #(
    parameter int NUM_CMP        = 2,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        address_in,
    input  logic               sel_in,
    input  logic               read_in,
    output logic [31:0]        read_value_out,
    input  logic [3:0]         write_mask_in,
    input  logic [31:0]        write_value_in,
    output logic               ready_out,
    output logic [NUM_CMP-1:0] timer_irq_out
);
    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t                    state;
    logic [63:0]               mtime, mtime_nx;
    logic                      en;
    logic [PRESCALE_WIDTH-1:0] prescale, prescale_nx;
    logic [PRESCALE_WIDTH-1:0] ps_cnt, ps_cnt_nx;
    logic [63:0]               cmp [NUM_CMP];
    logic [31:0]               rd_dat;
    logic [4:0]                offset;
    logic                      commit;
    logic                      unused_bits;

    assign offset      = address_in[6:2];
    assign commit      = (state == S_ACK) && (write_mask_in != 4'd0);
    assign unused_bits = ^{read_in, address_in[31:7], address_in[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = m[b] ? nw[8*b +: 8] : cur[8*b +: 8];
        return r;
    endfunction

`ifdef MTIMER_SNAPSHOT_EN
    // High word latched at the same edge an MTIMEL access captures its data.
    logic [31:0] mtime_hi_snap;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mtime_hi_snap <= '0;
        else if (state == S_IDLE && sel_in && offset == 5'd0)
            mtime_hi_snap <= mtime[63:32];
    end
`endif

    always_comb begin
        rd_dat = '0;
        case (offset)
            5'd0: rd_dat = mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            5'd1: rd_dat = mtime_hi_snap;
`else
            5'd1: rd_dat = mtime[63:32];
`endif
            5'd2: rd_dat = {31'd0, en};
            5'd3: rd_dat = 32'(prescale);
            default: begin
                for (int i = 0; i < NUM_CMP; i++) begin
                    if (offset == 5'(4 + 2*i)) rd_dat = cmp[i][31:0];
                    if (offset == 5'(5 + 2*i)) rd_dat = cmp[i][63:32];
                end
            end
        endcase
    end

    // Bus writes to the counter override the increment; any counter/prescale write restarts the divider.
    always_comb begin
        mtime_nx    = mtime;
        ps_cnt_nx   = ps_cnt;
        prescale_nx = prescale;
        if (en) begin
            if (ps_cnt == prescale) begin
                ps_cnt_nx = '0;
                mtime_nx  = mtime + 64'd1;
            end else begin
                ps_cnt_nx = ps_cnt + PRESCALE_WIDTH'(1);
            end
        end
        if (commit) begin
            case (offset)
                5'd0: begin
                    mtime_nx  = {mtime[63:32], merge(mtime[31:0], write_value_in, write_mask_in)};
                    ps_cnt_nx = '0;
                end
                5'd1: begin
                    mtime_nx  = {merge(mtime[63:32], write_value_in, write_mask_in), mtime[31:0]};
                    ps_cnt_nx = '0;
                end
                5'd3: begin
                    for (int j = 0; j < PRESCALE_WIDTH; j++)
                        if (write_mask_in[j/8]) prescale_nx[j] = write_value_in[j];
                    ps_cnt_nx = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime         <= '0;
            ps_cnt        <= '0;
            prescale      <= '0;
            en            <= 1'b1;
            timer_irq_out <= '0;
            for (int i = 0; i < NUM_CMP; i++) cmp[i] <= '1;
        end else begin
            mtime    <= mtime_nx;
            ps_cnt   <= ps_cnt_nx;
            prescale <= prescale_nx;
            if (commit && offset == 5'd2 && write_mask_in[0]) en <= write_value_in[0];
            for (int i = 0; i < NUM_CMP; i++) begin
                if (commit && offset == 5'(4 + 2*i))
                    cmp[i][31:0] <= merge(cmp[i][31:0], write_value_in, write_mask_in);
                if (commit && offset == 5'(5 + 2*i))
                    cmp[i][63:32] <= merge(cmp[i][63:32], write_value_in, write_mask_in);
                timer_irq_out[i] <= (mtime >= cmp[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ready_out      <= 1'b0;
            read_value_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (sel_in) begin
                    read_value_out <= rd_dat;
                    ready_out      <= 1'b1;
                    state          <= S_ACK;
                end
                S_ACK: begin
                    read_value_out <= '0;
                    ready_out      <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
